// File: rtl/pla_sweep_pkg.sv
// Shared types and helpers for the PLA truth-table sweeper.
// bin2gray is only referenced when SWEEP_GRAY_EN is defined.
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
  localparam logic [15:0] SIG_SEED_DEF = 16'h0000;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pla_sweep_misr.sv
// Single-input MISR: shift left, fold the MSB back through SIG_POLY, XOR the
// data bit into the LSB. i_clear has priority over i_en.
module pla_sweep_misr #(
  parameter int              SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_data,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_fb;

  assign w_fb = r_sig[SIG_W-1] ? SIG_POLY : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= SIG_SEED;
    end else if (i_clear) begin
      r_sig <= SIG_SEED;
    end else if (i_en) begin
      r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ {{(SIG_W-1){1'b0}}, i_data};
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/pla_truth_table_sweeper.sv
// Sweeps all 2^N_IN vectors into a benchmark netlist and accumulates ON-set
// count and MISR signature of y_in. Define SWEEP_GRAY_EN for Gray-order vectors.
module pla_truth_table_sweeper
  import pla_sweep_pkg::*;
#(
  parameter int               N_IN     = 14,
  parameter int               DUT_LAT  = 1,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(SIG_SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     onset_count,
  output logic [SIG_W-1:0]  signature,
  output sweep_state_e      dbg_state
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  sweep_state_e        r_state;
  logic [N_IN-1:0]     r_idx;
  logic [N_IN-1:0]     r_x;
  logic [DUT_LAT-1:0]  r_vpipe;
  logic [N_IN:0]       r_onset;
  logic                r_busy;
  logic                r_done;

  logic                w_start_ok;
  logic                w_push;
  logic                w_capture;
  logic [DUT_LAT-1:0]  w_pipe_nxt;
  logic [N_IN-1:0]     w_idx_nxt;
  logic [N_IN-1:0]     w_x_nxt;

  // start is a one-cycle request, accepted only from IDLE or DONE; no ready
  // is returned, so a start seen in DRIVE/DRAIN is simply dropped.
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Each DRIVE cycle tags the vector currently on x_out; its response is
  // sampled when the tag leaves the last pipe stage.
  assign w_push     = (r_state == ST_DRIVE);
  assign w_capture  = r_vpipe[DUT_LAT-1];
  assign w_pipe_nxt = DUT_LAT'({r_vpipe, w_push});
  assign w_idx_nxt  = r_idx + N_IN'(1);

`ifdef SWEEP_GRAY_EN
  assign w_x_nxt = N_IN'(bin2gray(32'(w_idx_nxt)));
`else
  assign w_x_nxt = w_idx_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_x     <= '0;
      r_vpipe <= '0;
      r_onset <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_vpipe <= w_pipe_nxt;
      if (w_capture) begin
        r_onset <= r_onset + (N_IN+1)'(y_in);
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state <= ST_DRIVE;
            r_idx   <= '0;
            r_x     <= '0;
            r_vpipe <= '0;
            r_onset <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          r_idx <= w_idx_nxt;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DRAIN;
          end else begin
            r_x <= w_x_nxt;
          end
        end
        ST_DRAIN: begin
          if (r_vpipe == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pla_sweep_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start_ok),
    .i_en    (w_capture),
    .i_data  (y_in),
    .o_sig   (signature)
  );

  assign x_out       = r_x;
  assign busy        = r_busy;
  assign done        = r_done;
  assign onset_count = r_onset;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pla_truth_table_sweeper.sv
// Bench for pla_truth_table_sweeper: a small N_IN=2/DUT_LAT=2 instance driven
// from a vector table and a full N_IN=14/DUT_LAT=1 instance for long sweeps.
module tb_pla_truth_table_sweeper;

  localparam int NB = 14;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Large instance and its model DUT: y = x_out[0] through one flop, or 0.
  logic          start_b = 1'b0;
  logic [NB-1:0] x_b;
  logic          y_b, dly_b, mode_b;
  logic          busy_b, done_b;
  logic [NB:0]   onset_b;
  logic [15:0]   sig_b;
  logic [1:0]    st_b;

  always @(posedge clk) dly_b <= x_b[0];
  assign y_b = mode_b ? dly_b : 1'b0;

  pla_truth_table_sweeper #(.N_IN(NB), .DUT_LAT(1)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x_out(x_b), .y_in(y_b),
    .busy(busy_b), .done(done_b), .onset_count(onset_b), .signature(sig_b),
    .dbg_state(st_b)
  );

  // Small instance: selectable 2-input function through two flops.
  logic          start_s = 1'b0;
  logic [NS-1:0] x_s;
  logic [2:0]    mode_s = 3'd0;
  logic          f_s, d1_s, d2_s;
  logic          busy_s, done_s;
  logic [NS:0]   onset_s;
  logic [15:0]   sig_s;
  logic [1:0]    st_s;

  always_comb begin
    f_s = 1'b0;
    case (mode_s)
      3'd1:    f_s = x_s[0] & x_s[1];
      3'd2:    f_s = x_s[0] | x_s[1];
      3'd3:    f_s = x_s[0] ^ x_s[1];
      3'd4:    f_s = x_s[0];
      3'd5:    f_s = x_s[1];
      default: f_s = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    d1_s <= f_s;
    d2_s <= d1_s;
  end

  pla_truth_table_sweeper #(.N_IN(NS), .DUT_LAT(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .x_out(x_s), .y_in(d2_s),
    .busy(busy_s), .done(done_s), .onset_count(onset_s), .signature(sig_s),
    .dbg_state(st_s)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [2:0]  onset;
    logic [15:0] sig;
  } small_vec_t;

  small_vec_t  tbl [6];
  logic [1:0]  xs_exp [5];
  logic [15:0] exp_sig_x0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference MISR over the large sweep with y = bit 0 of each vector.
  function automatic logic [15:0] model_sig_x0();
    logic [15:0] s;
    int unsigned xk;
    s = 16'h0000;
    for (int k = 0; k < (1 << NB); k++) begin
`ifdef SWEEP_GRAY_EN
      xk = k ^ (k >> 1);
`else
      xk = k;
`endif
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, xk[0]};
    end
    return s;
  endfunction

  task automatic run_small(input int row);
    int cyc;
    mode_s = tbl[row].mode;
    repeat (3) tick();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) check($sformatf("small_x_r%0d_c%0d", row, c), 32'(x_s), 32'(xs_exp[c]));
      check($sformatf("small_busy_r%0d_c%0d", row, c), 32'(busy_s), 32'd1);
      check($sformatf("small_done_low_r%0d_c%0d", row, c), 32'(done_s), 32'd0);
      tick();
    end
    check($sformatf("small_done_at7_r%0d", row), 32'(done_s), 32'd1);
    check($sformatf("small_busy_at7_r%0d", row), 32'(busy_s), 32'd0);
    cyc = 7;
    while (!done_s && cyc < 50) begin
      tick();
      cyc++;
    end
    check($sformatf("small_onset_r%0d", row), 32'(onset_s), 32'(tbl[row].onset));
    check($sformatf("small_sig_r%0d", row), 32'(sig_s), 32'(tbl[row].sig));
  endtask

  task automatic run_big(input string name, input logic mode, input int pulse_at,
                         input int exp_onset, input logic [15:0] exp_sig);
    int cyc;
    mode_b = mode;
    tick();
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check({name, "_clr_x"}, 32'(x_b), 32'd0);
    check({name, "_clr_onset"}, 32'(onset_b), 32'd0);
    check({name, "_clr_sig"}, 32'(sig_b), 32'd0);
    check({name, "_clr_busy"}, 32'(busy_b), 32'd1);
    check({name, "_clr_done"}, 32'(done_b), 32'd0);
    cyc = 0;
    while (!done_b && cyc < 20000) begin
      if (pulse_at >= 0 && int'(x_b) == pulse_at && busy_b) start_b = 1'b1;
      tick();
      start_b = 1'b0;
      cyc++;
    end
    check({name, "_cycles"}, 32'(cyc), 32'((1 << NB) + 2));
    check({name, "_onset"}, 32'(onset_b), 32'(exp_onset));
    check({name, "_sig"}, 32'(sig_b), 32'(exp_sig));
    repeat (3) tick();
    check({name, "_done_held"}, 32'(done_b), 32'd1);
    check({name, "_onset_held"}, 32'(onset_b), 32'(exp_onset));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
`ifdef SWEEP_GRAY_EN
    tbl[0] = '{3'd0, 3'd0, 16'h0000};
    tbl[1] = '{3'd1, 3'd1, 16'h0002};
    tbl[2] = '{3'd2, 3'd3, 16'h0007};
    tbl[3] = '{3'd3, 3'd2, 16'h0005};
    tbl[4] = '{3'd4, 3'd2, 16'h0006};
    tbl[5] = '{3'd5, 3'd2, 16'h0003};
    xs_exp = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2};
`else
    tbl[0] = '{3'd0, 3'd0, 16'h0000};
    tbl[1] = '{3'd1, 3'd1, 16'h0001};
    tbl[2] = '{3'd2, 3'd3, 16'h0007};
    tbl[3] = '{3'd3, 3'd2, 16'h0006};
    tbl[4] = '{3'd4, 3'd2, 16'h0005};
    tbl[5] = '{3'd5, 3'd2, 16'h0003};
    xs_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
`endif
    exp_sig_x0 = model_sig_x0();
    mode_b = 1'b0;

    // Reset values.
    repeat (3) tick();
    check("rst_x_b", 32'(x_b), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_done_b", 32'(done_b), 32'd0);
    check("rst_onset_b", 32'(onset_b), 32'd0);
    check("rst_sig_b", 32'(sig_b), 32'd0);
    check("rst_state_b", 32'(st_b), 32'd0);
    check("rst_state_s", 32'(st_s), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) run_small(r);

    // Full sweeps: y tied low, then y = x0 with a stray start mid-DRIVE
    // (launched from DONE, so also covers restart from DONE).
    run_big("zero", 1'b0, -1, 0, 16'h0000);
    run_big("x0_pulse", 1'b1, 100, 1 << (NB - 1), exp_sig_x0);

    // Abort mid-sweep with reset.
    mode_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    guard = 0;
    while (int'(x_b) != 5000 && guard < 20000) begin
      tick();
      guard++;
    end
    check("abort_reach_5000", 32'(x_b), 32'd5000);
    rst_n = 1'b0;
    #1;
    check("abort_x", 32'(x_b), 32'd0);
    check("abort_busy", 32'(busy_b), 32'd0);
    check("abort_done", 32'(done_b), 32'd0);
    check("abort_onset", 32'(onset_b), 32'd0);
    check("abort_sig", 32'(sig_b), 32'd0);
    start_b = 1'b1;
    tick();
    tick();
    start_b = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    check("start_in_reset_busy", 32'(busy_b), 32'd0);
    check("start_in_reset_state", 32'(st_b), 32'd0);

    run_big("x0_after_abort", 1'b1, -1, 1 << (NB - 1), exp_sig_x0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
